// File: rtl/pwr_ctr_decoder.sv
// rtl/pwr_ctr_decoder.sv - PWR_CTR0/1 handshake decoder producing power-off/reboot commands
module pwr_ctr_decoder #(
    parameter int FILT_CYCLES = 4,
    parameter int TMO_CYCLES  = 512,
    parameter int TMO_W       = 16
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       en_i,
    input  logic       PWR_CTR0_i,
    input  logic       PWR_CTR1_i,
    output logic       cmd_valid_o,
    output logic [1:0] cmd_o,
    output logic       seq_err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A1       = 3'd1,
        A2       = 3'd2,
        A3       = 3'd3,
        B1       = 3'd4,
        B2       = 3'd5,
        B3       = 3'd6,
        WAIT_LOW = 3'd7
    } state_t;

    localparam logic [7:0]       FILT_LAST = 8'(FILT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYCLES - 1);

    // Bit 0 carries PWR_CTR0, bit 1 carries PWR_CTR1 throughout.
    logic [1:0]       sync_q1, sync_q2;
    logic [1:0]       filt_q, rise_q, fall_q, chg;
    logic [7:0]       fcnt_q [2];
    state_t           state_q, state_d;
    logic             en_q;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;
    logic [1:0]       cmd_sel, err_sel;
    logic             ev_ok;
    state_t           ev_next;
    logic             busy_d, cmd_valid_d, seq_err_d;
    logic             busy_q, cmd_valid_q, seq_err_q;
    logic [1:0]       cmd_q, err_q;

    assign chg     = rise_q | fall_q;
    assign tmo_hit = (tmo_q == TMO_LAST);

    // Two-flop synchroniser for both asynchronous control lines
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q1 <= 2'b00;
            sync_q2 <= 2'b00;
        end else begin
            sync_q1 <= {PWR_CTR1_i, PWR_CTR0_i};
            sync_q2 <= sync_q1;
        end
    end

    // Glitch filter: the filtered level follows only after FILT_CYCLES stable cycles,
    // and the one-cycle edge flag is presented together with the new level
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            filt_q    <= 2'b00;
            rise_q    <= 2'b00;
            fall_q    <= 2'b00;
            fcnt_q[0] <= 8'd0;
            fcnt_q[1] <= 8'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                if (sync_q2[i] == filt_q[i]) begin
                    fcnt_q[i] <= 8'd0;
                end else if (fcnt_q[i] == FILT_LAST) begin
                    fcnt_q[i] <= 8'd0;
                    filt_q[i] <= sync_q2[i];
                    rise_q[i] <= sync_q2[i];
                    fall_q[i] <= ~sync_q2[i];
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 8'd1;
                end
            end
        end
    end

    // State, timeout counter and registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= 2'b00;
            seq_err_q   <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            en_q        <= en_i;
            busy_q      <= busy_d;
            cmd_valid_q <= cmd_valid_d;
            seq_err_q   <= seq_err_d;
            if (cmd_valid_d) cmd_q <= cmd_sel;
            if (seq_err_d)   err_q <= err_sel;
            if (state_d != state_q || !busy_q) tmo_q <= '0;
            else                               tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    // Expected next event for each active state of the two handshake sequences
    always_comb begin
        ev_ok   = 1'b0;
        ev_next = IDLE;
        case (state_q)
            A1:      begin ev_ok = rise_q[1]; ev_next = A2;   end
            A2:      begin ev_ok = fall_q[1]; ev_next = A3;   end
            A3:      begin ev_ok = fall_q[0]; ev_next = IDLE; end
            B1:      begin ev_ok = rise_q[0]; ev_next = B2;   end
            B2:      begin ev_ok = fall_q[0]; ev_next = B3;   end
            B3:      begin ev_ok = fall_q[1]; ev_next = IDLE; end
            default: begin ev_ok = 1'b0;      ev_next = IDLE; end
        endcase
    end

    // Next-state decision with command/error selection
    always_comb begin
        state_d = state_q;
        cmd_sel = 2'b00;
        err_sel = 2'b00;
        if (!en_i) begin
            state_d = IDLE;
        end else if (!en_q) begin
            // Arming while a line is still high must not start mid-handshake
            state_d = (|filt_q) ? WAIT_LOW : IDLE;
        end else if (state_q == WAIT_LOW) begin
            if (filt_q == 2'b00) state_d = IDLE;
        end else if (&chg) begin
            err_sel = 2'b11;
            state_d = WAIT_LOW;
        end else if (state_q == IDLE) begin
            if (rise_q[0])      state_d = A1;
            else if (rise_q[1]) state_d = B1;
        end else if (|chg) begin
            if (ev_ok) begin
                state_d = ev_next;
                if (state_q == A3) cmd_sel = 2'b01;
                if (state_q == B3) cmd_sel = 2'b10;
            end else begin
                err_sel = 2'b10;
                state_d = WAIT_LOW;
            end
        end else if (tmo_hit) begin
            err_sel = 2'b01;
            state_d = WAIT_LOW;
        end
    end

    // Output decode of the upcoming state and strobes
    always_comb begin
        busy_d      = (state_d != IDLE) && (state_d != WAIT_LOW);
        cmd_valid_d = |cmd_sel;
        seq_err_d   = |err_sel;
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_o       = cmd_q;
    assign seq_err_o   = seq_err_q;
    assign err_code_o  = err_q;
    assign busy_o      = busy_q;
    assign state_o     = state_q;

endmodule
